voice_mixer: RTL and testbench
==============================

# voice_mixer

Mixes the three per-voice sine samples from the note player into the single 16-bit sample the codec consumes. On each codec request it collects one sample from every active voice, sums them with sign extension, scales and saturates, then presents the result with a one-cycle ready pulse. It sits directly downstream of the note player and directly upstream of the codec interface.

## Interface
- `SHIFT`, default 2: arithmetic right-shift applied to the 20-bit sum before saturation.
- `TIMEOUT`, default 255: cycles in COLLECT before missing voices are forced to zero. Range 1..255.
- `clk` input 1: system clock.
- `reset` input 1: the only reset. Asynchronous, active-low.
- `generate_next_sample` input 1: request pulse from the codec.
- `voice_active` input 3: bit n is high when voice n+1 is currently sounding.
- `sample_in1`, `sample_in2`, `sample_in3` input 18 each: signed two's-complement voice samples.
- `sample_ready1`, `sample_ready2`, `sample_ready3` input 1 each: single-cycle valid pulse for the matching `sample_in`.
- `sample_out` output 16: signed mixed sample. Held between updates.
- `new_sample_ready` output 1: single-cycle pulse when `sample_out` updates.
- `busy` output 1: high whenever the state is not IDLE.
- `drop_count` output 8: saturating count of ignored requests and timeouts.

## Operation
- FSM states: IDLE, COLLECT, SUM, OUT. Reset state is IDLE.
- IDLE:
  - On `generate_next_sample`, clear all captured samples and all got-flags.
  - Latch `voice_active` into `act_q`.
  - Clear the timeout counter and go to COLLECT.
- COLLECT:
  - For each voice n: if `sample_readyn` is high and got-flag n is clear, capture `sample_inn` and set got-flag n.
  - A voice with `act_q[n]==0` counts as already got, with value 0.
  - When every flag is set, go to SUM. The flag set on the cycle `sample_readyn` arrives counts in that same cycle's completion check.
  - The timeout counter increments every cycle in COLLECT. When it reaches `TIMEOUT`, go to SUM with missing voices contributing 0, and increment `drop_count`.
- SUM:
  - Sign-extend each capture to 20 bits and add into a 20-bit sum. This cannot overflow.
  - Compute `sum >>> SHIFT`, then clamp to the range -32768..32767.
  - Register the clamped value into the `sample_out` register and go to OUT.
- OUT: `new_sample_ready`=1 for this one cycle, then go to IDLE.
- A `generate_next_sample` that arrives in any state other than IDLE is ignored and increments `drop_count`.
- `drop_count` saturates at 255. It never wraps.
- Any `sample_ready` pulse outside COLLECT is ignored. A second pulse from an already-captured voice is also ignored; the first value is kept.
- If `act_q`==0 on entry to COLLECT, the flags are complete immediately. SUM produces 0.
- Changes to `voice_active` after the latch have no effect until the next request.
- Reset mid-operation: asynchronously force IDLE and clear every register. Any pending request is lost, with no ready pulse.

## Timing
- Reset values:
  - `sample_out`=0, `new_sample_ready`=0, `busy`=0, `drop_count`=0.
  - Flags, captures and timeout counter are all 0.
- Request in cycle 0 → COLLECT in cycle 1.
- The last required `sample_ready` in cycle k (k≥1) → SUM in k+1 → `new_sample_ready` high and `sample_out` valid in k+2.
- All voices inactive: `new_sample_ready` in cycle 3.
- Timeout with no readies: COLLECT spans cycles 1..TIMEOUT, SUM in TIMEOUT+1, pulse in TIMEOUT+2.
- All outputs are registered. There is no combinational path from inputs to outputs.
- A request accepted in the cycle after OUT (IDLE) is serviced normally. The minimum request spacing is 4 cycles.

## Test plan
- Reset and scaled sum:
  - Stimulus: hold `reset` low, release. Then `voice_active`=3'b111, request, then readies for inputs 4000, 8000, -4000 in cycles 3, 5 and 7.
  - Required: all outputs 0 during reset. Then `new_sample_ready` in cycle 9 with `sample_out`=2000 (8000>>>2).
- Positive saturation: all three inputs 18'h1FFFF (131071), all active → `sample_out`=32767. `drop_count` stays 0.
- Negative saturation and inactive voice:
  - Stimulus: inputs 18'h20000 ×2, `voice_active`=3'b011, voice 3 pulses 18'h1FFFF anyway.
  - Required: `sample_out`=-32768 (sum -262144>>>2 = -65536, clamped); the voice-3 pulse is ignored.
- Timeout: `TIMEOUT`=10, all active, only voices 1–2 pulse 400 and 800.
  - Required: `new_sample_ready` in cycle 12 with `sample_out`=300, and `drop_count`=1.
- Overrun, duplicate pulse, and mid-operation reset:
  - A second request while COLLECT is active → `drop_count` increments and there is no extra ready pulse.
  - A repeated voice-1 pulse with a new value → the first value is kept.
  - Assert `reset` during COLLECT → IDLE immediately and no ready pulse.

Source files
------------

// File: rtl/voice_mixer.sv
// Three-voice sample mixer: gathers one sample per active voice on each codec
// request, sums with sign extension, scales, saturates and presents a 16-bit result.
module voice_mixer #(
    parameter int SHIFT   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        generate_next_sample,
    input  logic [2:0]  voice_active,
    input  logic [17:0] sample_in1,
    input  logic [17:0] sample_in2,
    input  logic [17:0] sample_in3,
    input  logic        sample_ready1,
    input  logic        sample_ready2,
    input  logic        sample_ready3,
    output logic [15:0] sample_out,
    output logic        new_sample_ready,
    output logic        busy,
    output logic [7:0]  drop_count
);

    // state   | meaning
    // IDLE    | waiting for a codec request
    // COLLECT | capturing one sample from each latched-active voice
    // SUM     | sum, scale and saturate captures into sample_out
    // OUT     | new_sample_ready pulse visible, then back to IDLE
    typedef enum logic [1:0] {IDLE, COLLECT, SUM, OUT} state_t;

    state_t             state;
    logic [2:0]         act_q;
    logic [2:0]         got;
    logic [17:0]        cap [3];
    logic [7:0]         tmo_cnt;

    logic [17:0]        s_in [3];
    logic [2:0]         rdy;
    logic [2:0]         got_eff;
    logic [2:0]         take;
    logic [2:0]         got_next;
    logic               complete;
    logic               timeout_hit;
    logic               overrun;
    logic [8:0]         drop_sum;
    logic signed [19:0] sum_w;
    logic signed [19:0] shifted;
    logic [15:0]        clamped;

    always_comb begin
        s_in[0]     = sample_in1;
        s_in[1]     = sample_in2;
        s_in[2]     = sample_in3;
        rdy         = {sample_ready3, sample_ready2, sample_ready1};
        // Inactive voices read as already captured so they neither block nor load.
        got_eff     = got | ~act_q;
        take        = rdy & ~got_eff;
        got_next    = got_eff | take;
        complete    = &got_next;
        timeout_hit = (state == COLLECT) && !complete && (tmo_cnt == 8'(TIMEOUT - 1));
        overrun     = generate_next_sample && (state != IDLE);
        drop_sum    = {1'b0, drop_count} + 9'(overrun) + 9'(timeout_hit);

        sum_w   = signed'({{2{cap[0][17]}}, cap[0]})
                + signed'({{2{cap[1][17]}}, cap[1]})
                + signed'({{2{cap[2][17]}}, cap[2]});
        shifted = sum_w >>> SHIFT;
        if (shifted > 20'sd32767)
            clamped = 16'h7FFF;
        else if (shifted < -20'sd32768)
            clamped = 16'h8000;
        else
            clamped = shifted[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            act_q            <= '0;
            got              <= '0;
            cap              <= '{default: '0};
            tmo_cnt          <= '0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
            busy             <= 1'b0;
            drop_count       <= '0;
        end else begin
            new_sample_ready <= 1'b0;
            drop_count       <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            case (state)
                IDLE: begin
                    if (generate_next_sample) begin
                        got     <= '0;
                        cap     <= '{default: '0};
                        act_q   <= voice_active;
                        tmo_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    for (int n = 0; n < 3; n++)
                        if (take[n]) cap[n] <= s_in[n];
                    got     <= got_next;
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (complete || timeout_hit)
                        state <= SUM;
                end
                SUM: begin
                    sample_out       <= clamped;
                    new_sample_ready <= 1'b1;
                    state            <= OUT;
                end
                OUT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: scaled sum, saturation, inactive voices,
// timeout, overrun, duplicate pulses and mid-operation reset.
module tb_voice_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic        generate_next_sample;
    logic [2:0]  voice_active;
    logic [17:0] sample_in1, sample_in2, sample_in3;
    logic        sample_ready1, sample_ready2, sample_ready3;
    logic [15:0] sample_out;
    logic        new_sample_ready;
    logic        busy;
    logic [7:0]  drop_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_mark;

    voice_mixer #(.SHIFT(2), .TIMEOUT(10)) dut (
        .clk(clk),
        .reset(reset),
        .generate_next_sample(generate_next_sample),
        .voice_active(voice_active),
        .sample_in1(sample_in1),
        .sample_in2(sample_in2),
        .sample_in3(sample_in3),
        .sample_ready1(sample_ready1),
        .sample_ready2(sample_ready2),
        .sample_ready3(sample_ready3),
        .sample_out(sample_out),
        .new_sample_ready(new_sample_ready),
        .busy(busy),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (new_sample_ready === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Request issued in cycle 0; returns in cycle 1.
    task automatic req();
        cyc = 0;
        generate_next_sample = 1'b1;
        tick(1);
        generate_next_sample = 1'b0;
    endtask

    task automatic rdy(input int v, input logic [17:0] val);
        case (v)
            1: begin sample_in1 = val; sample_ready1 = 1'b1; end
            2: begin sample_in2 = val; sample_ready2 = 1'b1; end
            default: begin sample_in3 = val; sample_ready3 = 1'b1; end
        endcase
        tick(1);
        sample_ready1 = 1'b0;
        sample_ready2 = 1'b0;
        sample_ready3 = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        generate_next_sample = 1'b0;
        voice_active = 3'b000;
        sample_in1 = '0; sample_in2 = '0; sample_in3 = '0;
        sample_ready1 = 1'b0; sample_ready2 = 1'b0; sample_ready3 = 1'b0;
        tick(3);
        check("rst_sample_out", 32'(sample_out), 32'd0);
        check("rst_ready", 32'(new_sample_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        reset = 1'b1;
        tick(2);

        // Scaled sum: 4000 + 8000 - 4000 = 8000, >>>2 = 2000, pulse in cycle 9
        voice_active = 3'b111;
        req();
        check("t1_busy", 32'(busy), 32'd1);
        tick(2);
        rdy(1, 18'd4000);
        tick(1);
        rdy(2, 18'd8000);
        tick(1);
        rdy(3, -18'sd4000);
        check("t1_no_early_ready", 32'(new_sample_ready), 32'd0);
        tick(1);
        check("t1_cycle", 32'(cyc), 32'd9);
        check("t1_ready", 32'(new_sample_ready), 32'd1);
        check("t1_sample", 32'(sample_out), 32'd2000);
        tick(1);
        check("t1_ready_single", 32'(new_sample_ready), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_held", 32'(sample_out), 32'd2000);

        // Positive saturation
        req();
        rdy(1, 18'h1FFFF);
        rdy(2, 18'h1FFFF);
        rdy(3, 18'h1FFFF);
        tick(1);
        check("t2_ready", 32'(new_sample_ready), 32'd1);
        check("t2_sample", 32'(sample_out), 32'h7FFF);
        check("t2_drop", 32'(drop_count), 32'd0);
        tick(1);

        // Negative saturation, voice 3 inactive; later voice_active change has no effect
        voice_active = 3'b011;
        req();
        voice_active = 3'b111;
        rdy(3, 18'h1FFFF);
        rdy(1, 18'h20000);
        rdy(2, 18'h20000);
        tick(1);
        check("t3_ready", 32'(new_sample_ready), 32'd1);
        check("t3_sample", 32'(sample_out), 32'h8000);
        tick(1);

        // Timeout with TIMEOUT=10: (400 + 800) >>> 2 = 300, pulse in cycle 12
        voice_active = 3'b111;
        req();
        rdy(1, 18'd400);
        rdy(2, 18'd800);
        tick(11 - cyc);
        check("t4_no_ready_c11", 32'(new_sample_ready), 32'd0);
        check("t4_busy_c11", 32'(busy), 32'd1);
        tick(1);
        check("t4_ready_c12", 32'(new_sample_ready), 32'd1);
        check("t4_sample", 32'(sample_out), 32'd300);
        check("t4_drop", 32'(drop_count), 32'd1);
        tick(1);

        // Overrun request and duplicate voice-1 pulse: 1000 >>> 2 = 250
        voice_active = 3'b011;
        pulse_mark = pulse_cnt;
        req();
        generate_next_sample = 1'b1;
        tick(1);
        generate_next_sample = 1'b0;
        check("t5_drop_overrun", 32'(drop_count), 32'd2);
        rdy(1, 18'd1000);
        rdy(1, 18'd2000);
        rdy(2, 18'd0);
        tick(1);
        check("t5_ready", 32'(new_sample_ready), 32'd1);
        check("t5_first_kept", 32'(sample_out), 32'd250);
        tick(4);
        check("t5_one_pulse", 32'(pulse_cnt - pulse_mark), 32'd1);
        check("t5_idle", 32'(busy), 32'd0);

        // All voices inactive: pulse in cycle 3 with zero
        voice_active = 3'b000;
        req();
        tick(2);
        check("t6_ready_c3", 32'(new_sample_ready), 32'd1);
        check("t6_sample", 32'(sample_out), 32'd0);
        tick(1);

        // Back-to-back: sample_out nonzero before the reset test
        voice_active = 3'b001;
        req();
        rdy(1, 18'd40);
        tick(1);
        check("t7_sample", 32'(sample_out), 32'd10);
        tick(1);

        // Reset during COLLECT
        voice_active = 3'b111;
        req();
        rdy(1, 18'd4000);
        check("t8_busy_pre", 32'(busy), 32'd1);
        pulse_mark = pulse_cnt;
        reset = 1'b0;
        #2;
        check("t8_busy_async", 32'(busy), 32'd0);
        check("t8_sample_clr", 32'(sample_out), 32'd0);
        check("t8_drop_clr", 32'(drop_count), 32'd0);
        #2;
        reset = 1'b1;
        rdy(2, 18'd8000);
        rdy(3, 18'd100);
        tick(12);
        check("t8_no_pulse", 32'(pulse_cnt - pulse_mark), 32'd0);
        check("t8_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
